// File: rtl/acc_pkg.sv
// Shared types and widths for the accumulator scheduler.
package acc_pkg;
   localparam int B_W   = 3;
   localparam int Y_W   = 8;
   localparam int LEN_W = 3;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;
endpackage

// File: rtl/acc_sched_rr_pick2.sv
// Two-way round-robin pick: on a tie the requester that was not served last wins.
module rr_pick2 (
   input  logic req0,
   input  logic req1,
   input  logic last,
   output logic winner,
   output logic any
);
   assign any    = req0 | req1;
   assign winner = req1 & (~req0 | ~last);
endmodule

// File: rtl/acc_sched.sv
// Schedules two requesters onto one shared accumulator in fixed-length bursts.
// state | meaning
// IDLE  | accumulator fed add-zero; arbitrate pending/live requests
// RUN   | owner's captured sel/b drive the accumulator; counter runs down to 0
module acc_sched
   import acc_pkg::*;
(
   input  logic             clk,
   input  logic             r,
   input  logic             req0,
   input  logic             req1,
   input  logic             sel0,
   input  logic             sel1,
   input  logic [B_W-1:0]   b0,
   input  logic [B_W-1:0]   b1,
   input  logic [LEN_W-1:0] len0,
   input  logic [LEN_W-1:0] len1,
   output logic             gnt0,
   output logic             gnt1,
   output logic             done0,
   output logic             done1,
   output logic             abort0,
   output logic             abort1,
   output logic             acc_sel,
   output logic [B_W-1:0]   acc_b,
   input  logic [Y_W-1:0]   acc_y,
   output logic             wrap
);
   state_t           state;
   logic             owner;
   logic             last_served;
   logic [LEN_W-1:0] cnt;
   logic             cap_sel;
   logic [B_W-1:0]   cap_b;
   logic [Y_W-1:0]   y_prev;
   logic             pend0;
   logic             pend1;
   logic             pick;
   logic             pick_any;
   logic             owner_req;
   logic             wrap_hit;

   // Requests seen during a burst are latched so a short pulse is not lost.
   rr_pick2 u_pick (
      .req0   (req0 | pend0),
      .req1   (req1 | pend1),
      .last   (last_served),
      .winner (pick),
      .any    (pick_any)
   );

   assign owner_req = owner ? req1 : req0;
   assign wrap_hit  = (state == RUN) && !cap_sel && (cap_b != '0) && (acc_y < y_prev);

   always_ff @(posedge clk or negedge r) begin
      if (!r) begin
         state       <= IDLE;
         owner       <= 1'b0;
         last_served <= 1'b1;
         cnt         <= '0;
         cap_sel     <= 1'b0;
         cap_b       <= '0;
         y_prev      <= '0;
         pend0       <= 1'b0;
         pend1       <= 1'b0;
         gnt0        <= 1'b0;
         gnt1        <= 1'b0;
         done0       <= 1'b0;
         done1       <= 1'b0;
         abort0      <= 1'b0;
         abort1      <= 1'b0;
         acc_sel     <= 1'b0;
         acc_b       <= '0;
         wrap        <= 1'b0;
      end else begin
         y_prev <= acc_y;
         done0  <= 1'b0;
         done1  <= 1'b0;
         abort0 <= 1'b0;
         abort1 <= 1'b0;
         if (wrap_hit) wrap <= 1'b1;
         case (state)
            IDLE: begin
               if (pick_any) begin
                  state   <= RUN;
                  owner   <= pick;
                  cap_sel <= pick ? sel1 : sel0;
                  cap_b   <= pick ? b1 : b0;
                  cnt     <= pick ? len1 : len0;
                  acc_sel <= pick ? sel1 : sel0;
                  acc_b   <= pick ? b1 : b0;
                  gnt0    <= ~pick;
                  gnt1    <= pick;
                  if (pick) pend1 <= 1'b0;
                  else      pend0 <= 1'b0;
               end
            end
            RUN: begin
               if (owner) pend0 <= pend0 | req0;
               else       pend1 <= pend1 | req1;
               if (!owner_req || cnt == '0) begin
                  state       <= IDLE;
                  last_served <= owner;
                  cnt         <= '0;
                  gnt0        <= 1'b0;
                  gnt1        <= 1'b0;
                  acc_sel     <= 1'b0;
                  acc_b       <= '0;
                  // A dropped request takes precedence over reaching terminal count.
                  if (!owner_req) begin
                     abort0 <= ~owner;
                     abort1 <= owner;
                  end else begin
                     done0 <= ~owner;
                     done1 <= owner;
                  end
               end else begin
                  cnt <= cnt - LEN_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_acc_sched.sv
// Scoreboarded bench for acc_sched: per-cycle expected output vectors are queued with the stimulus.
module tb_acc_sched;
   logic       clk = 1'b0;
   logic       r;
   logic       req0, req1, sel0, sel1;
   logic [2:0] b0, b1, len0, len1;
   logic       gnt0, gnt1, done0, done1, abort0, abort1, acc_sel, wrap;
   logic [2:0] acc_b;
   logic [7:0] acc_y;

   int checks   = 0;
   int failures = 0;
   logic [10:0] sb[$];

   acc_sched dut (
      .clk(clk), .r(r),
      .req0(req0), .req1(req1), .sel0(sel0), .sel1(sel1),
      .b0(b0), .b1(b1), .len0(len0), .len1(len1),
      .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
      .abort0(abort0), .abort1(abort1),
      .acc_sel(acc_sel), .acc_b(acc_b), .acc_y(acc_y), .wrap(wrap)
   );

   always #5 clk = ~clk;

   // Vector layout: {wrap, gnt0, gnt1, done0, done1, abort0, abort1, acc_sel, acc_b}
   function automatic logic [10:0] ev(input logic w, g0, g1, d0, d1, a0, a1, s, input logic [2:0] b);
      return {w, g0, g1, d0, d1, a0, a1, s, b};
   endfunction

   function automatic logic [10:0] obs();
      return {wrap, gnt0, gnt1, done0, done1, abort0, abort1, acc_sel, acc_b};
   endfunction

   task automatic zero_inputs();
      req0 = 0; req1 = 0; sel0 = 0; sel1 = 0;
      b0 = 0; b1 = 0; len0 = 0; len1 = 0; acc_y = 0;
   endtask

   task automatic apply_reset();
      r = 1'b0;
      zero_inputs();
      @(posedge clk); #1;
      r = 1'b1;
   endtask

   task automatic test_reset();
      logic [10:0] e, got;
      r = 1'b0;
      zero_inputs();
      #3;
      sb.push_back(ev(0,0,0,0,0,0,0,0,3'd0));
      got = obs(); e = sb.pop_front(); checks++;
      if (got !== e) begin failures++; $display("FAIL reset_async got=%h exp=%h", got, e); end
      @(posedge clk); #1;
      sb.push_back(ev(0,0,0,0,0,0,0,0,3'd0));
      got = obs(); e = sb.pop_front(); checks++;
      if (got !== e) begin failures++; $display("FAIL reset_held got=%h exp=%h", got, e); end
      r = 1'b1;
   endtask

   task automatic test_basic();
      logic [10:0] e, got;
      apply_reset();
      for (int i = 0; i < 6; i++) begin
         req0 = (i < 4); b0 = 3'd3; sel0 = 1'b0; len0 = 3'd2;
         case (i)
            0, 1, 2: sb.push_back(ev(0,1,0,0,0,0,0,0,3'd3));
            3:       sb.push_back(ev(0,0,0,1,0,0,0,0,3'd0));
            default: sb.push_back(ev(0,0,0,0,0,0,0,0,3'd0));
         endcase
         @(posedge clk); #1;
         got = obs(); e = sb.pop_front(); checks++;
         if (got !== e) begin failures++; $display("FAIL basic cyc%0d got=%h exp=%h", i, got, e); end
      end
   endtask

   task automatic test_round_robin();
      logic [10:0] e, got;
      apply_reset();
      b0 = 3'd1; sel0 = 1'b0; len0 = 3'd0;
      b1 = 3'd2; sel1 = 1'b1; len1 = 3'd0;
      req0 = 1'b1; req1 = 1'b1;
      for (int i = 0; i < 8; i++) begin
         case (i % 4)
            0:       sb.push_back(ev(0,1,0,0,0,0,0,0,3'd1));
            1:       sb.push_back(ev(0,0,0,1,0,0,0,0,3'd0));
            2:       sb.push_back(ev(0,0,1,0,0,0,0,1,3'd2));
            default: sb.push_back(ev(0,0,0,0,1,0,0,0,3'd0));
         endcase
         @(posedge clk); #1;
         got = obs(); e = sb.pop_front(); checks++;
         if (got !== e) begin failures++; $display("FAIL rr cyc%0d got=%h exp=%h", i, got, e); end
      end
      req0 = 1'b0; req1 = 1'b0;
   endtask

   task automatic test_abort();
      logic [10:0] e, got;
      apply_reset();
      b1 = 3'd5; sel1 = 1'b1; len1 = 3'd7;
      for (int i = 0; i < 6; i++) begin
         req1 = (i < 4);
         case (i)
            0, 1, 2, 3: sb.push_back(ev(0,0,1,0,0,0,0,1,3'd5));
            4:          sb.push_back(ev(0,0,0,0,0,0,1,0,3'd0));
            default:    sb.push_back(ev(0,0,0,0,0,0,0,0,3'd0));
         endcase
         @(posedge clk); #1;
         got = obs(); e = sb.pop_front(); checks++;
         if (got !== e) begin failures++; $display("FAIL abort cyc%0d got=%h exp=%h", i, got, e); end
      end
   endtask

   task automatic test_capture_pending();
      logic [10:0] e, got;
      apply_reset();
      b1 = 3'd2; sel1 = 1'b0; len1 = 3'd0;
      for (int i = 0; i < 8; i++) begin
         case (i)
            0: begin req0 = 1; b0 = 3'd3; sel0 = 0; len0 = 3'd3; end
            1: begin b0 = 3'd6; sel0 = 1; len0 = 3'd0; end
            2: req1 = 1;
            3: req1 = 0;
            5: req0 = 0;
            6: req1 = 1;
            7: req1 = 0;
            default: ;
         endcase
         case (i)
            0, 1, 2, 3: sb.push_back(ev(0,1,0,0,0,0,0,0,3'd3));
            4:          sb.push_back(ev(0,0,0,1,0,0,0,0,3'd0));
            5:          sb.push_back(ev(0,0,1,0,0,0,0,0,3'd2));
            6:          sb.push_back(ev(0,0,0,0,1,0,0,0,3'd0));
            default:    sb.push_back(ev(0,0,0,0,0,0,0,0,3'd0));
         endcase
         @(posedge clk); #1;
         got = obs(); e = sb.pop_front(); checks++;
         if (got !== e) begin failures++; $display("FAIL capture cyc%0d got=%h exp=%h", i, got, e); end
      end
   endtask

   task automatic test_wrap();
      logic [10:0] e, got;
      apply_reset();
      sel0 = 1'b0; b0 = 3'd6; len0 = 3'd3;
      for (int i = 0; i < 7; i++) begin
         req0 = (i < 5);
         case (i)
            0, 1:    acc_y = 8'd250;
            2:       acc_y = 8'd4;
            default: acc_y = 8'd10;
         endcase
         case (i)
            0, 1:    sb.push_back(ev(0,1,0,0,0,0,0,0,3'd6));
            2, 3:    sb.push_back(ev(1,1,0,0,0,0,0,0,3'd6));
            4:       sb.push_back(ev(1,0,0,1,0,0,0,0,3'd0));
            default: sb.push_back(ev(1,0,0,0,0,0,0,0,3'd0));
         endcase
         @(posedge clk); #1;
         got = obs(); e = sb.pop_front(); checks++;
         if (got !== e) begin failures++; $display("FAIL wrap cyc%0d got=%h exp=%h", i, got, e); end
      end
      acc_y = 8'd0;
   endtask

   // Continues from the sticky-wrap state left by test_wrap.
   task automatic test_reset_mid();
      logic [10:0] e, got;
      req1 = 1'b0;
      req0 = 1'b1; len0 = 3'd5; b0 = 3'd4; sel0 = 1'b1;
      for (int i = 0; i < 2; i++) begin
         sb.push_back(ev(1,1,0,0,0,0,0,1,3'd4));
         @(posedge clk); #1;
         got = obs(); e = sb.pop_front(); checks++;
         if (got !== e) begin failures++; $display("FAIL rstmid_run cyc%0d got=%h exp=%h", i, got, e); end
      end
      #2 r = 1'b0;
      #1;
      sb.push_back(ev(0,0,0,0,0,0,0,0,3'd0));
      got = obs(); e = sb.pop_front(); checks++;
      if (got !== e) begin failures++; $display("FAIL rstmid_async got=%h exp=%h", got, e); end
      req0 = 1; req1 = 1; len0 = 0; len1 = 0; b0 = 3'd1; b1 = 3'd2; sel0 = 0; sel1 = 0;
      @(posedge clk); #1;
      sb.push_back(ev(0,0,0,0,0,0,0,0,3'd0));
      got = obs(); e = sb.pop_front(); checks++;
      if (got !== e) begin failures++; $display("FAIL rstmid_held got=%h exp=%h", got, e); end
      #2 r = 1'b1;
      sb.push_back(ev(0,1,0,0,0,0,0,0,3'd1));
      @(posedge clk); #1;
      got = obs(); e = sb.pop_front(); checks++;
      if (got !== e) begin failures++; $display("FAIL rstmid_tie got=%h exp=%h", got, e); end
      sb.push_back(ev(0,0,0,1,0,0,0,0,3'd0));
      @(posedge clk); #1;
      got = obs(); e = sb.pop_front(); checks++;
      if (got !== e) begin failures++; $display("FAIL rstmid_done got=%h exp=%h", got, e); end
      req0 = 0; req1 = 0;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_round_robin();
      test_abort();
      test_capture_pending();
      test_wrap();
      test_reset_mid();
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_left got=%0d exp=0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/acc_sched.md
ACC_SCHED -- requirements
Module: acc_sched

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-002 SHALL have port r, input, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have ports req0 and req1, input, 1 bit each: requester asks for the accumulator.
REQ-004 SHALL have ports sel0 and sel1, input, 1 bit each: requester operation select, forwarded to the accumulator sel.
REQ-005 SHALL have ports b0 and b1, input, 3 bits each: requester operand.
REQ-006 SHALL have ports len0 and len1, input, 3 bits each: burst length minus 1, giving 1..8 cycles.
REQ-007 SHALL have ports gnt0 and gnt1, output, 1 bit each: requester owns the accumulator.
REQ-008 SHALL have ports done0 and done1, output, 1 bit each: one-cycle pulse when a burst completes normally.
REQ-009 SHALL have ports abort0 and abort1, output, 1 bit each: one-cycle pulse when a burst is cut short.
REQ-010 SHALL have port acc_sel, output, 1 bit: drives the accumulator sel.
REQ-011 SHALL have port acc_b, output, 3 bits: drives the accumulator B.
REQ-012 SHALL have port acc_y, input, 8 bits: accumulator Y, observed only.
REQ-013 SHALL have port wrap, output, 1 bit: sticky flag, accumulator wrapped during an add.

Function
REQ-014 SHALL implement an FSM with states IDLE and RUN, plus an owner register (0/1) and a last-served register (0/1).
REQ-015 In IDLE SHALL drive acc_sel=0 and acc_b=0 (add zero, accumulator holds).
REQ-016 In IDLE with exactly one req high at a clock edge, SHALL enter RUN with that requester as owner.
REQ-017 In IDLE with both req high, SHALL grant the requester that is not last-served (round-robin).
REQ-018 On entering RUN SHALL capture the owner's sel, b and len into internal registers; input changes during the burst are ignored.
REQ-019 In RUN SHALL drive acc_sel and acc_b from the captured values and assert gnt of the owner only.
REQ-020 gnt SHALL be registered, asserted in the first RUN cycle, and held for exactly len+1 cycles.
REQ-021 The burst counter SHALL load len on grant and decrement once per RUN cycle.
REQ-022 When the counter is 0 in RUN, at the next edge SHALL go to IDLE, pulse done for one cycle, and update last-served to the owner.
REQ-023 If the owner's req is low during a RUN cycle, at the next edge SHALL go to IDLE, pulse abort instead of done, and update last-served to the owner.
REQ-024 SHALL spend at least one IDLE cycle between any two bursts (back-to-back requests are served with a 1-cycle gap).
REQ-025 A req from the non-owner during RUN SHALL be held pending and not lost; it is arbitrated at the next IDLE per REQ-016/017.
REQ-026 SHALL register acc_y each cycle as y_prev.
REQ-027 In RUN with captured sel=0, captured b not 0, and acc_y < y_prev, SHALL set wrap at the next edge.
REQ-028 wrap SHALL clear only on reset.
REQ-029 gnt0 and gnt1 SHALL never be high together; done and abort for the same requester SHALL never be high together.

Reset
REQ-030 While r=0, asynchronously: state=IDLE; last-served=1, so requester 0 wins the first tie.
REQ-031 While r=0, asynchronously: all gnt, done, abort and wrap = 0; acc_sel=0; acc_b=0; counter=0; y_prev=0.
REQ-032 Reset asserted mid-burst SHALL terminate the burst immediately, with no done or abort pulse.

Structure
REQ-033 A shared package acc_pkg SHALL hold the state enum (IDLE, RUN) and the widths B_W=3, Y_W=8, LEN_W=3.
REQ-034 Round-robin choice SHALL be a sub-module rr_pick2, purely combinational: inputs req0, req1, last; output winner and any.

Verification
REQ-035 Reset then req0=1, b0=3, sel0=0, len0=2: gnt0 high 3 cycles, acc_b=3 for those 3 cycles, done0 pulses once, then acc_b=0.
REQ-036 req0 and req1 both high continuously, len=0 each: grants alternate 0,1,0,1 with one IDLE cycle between; first grant is requester 0.
REQ-037 req1=1, len1=7; drop req1 in the 4th RUN cycle: abort1 pulses, done1 stays 0, gnt1 lasts 4 cycles.
REQ-038 Force acc_y from 250 to 4 while owner burst has sel=0, b=6: wrap=1 next cycle and stays 1 after the burst ends.
REQ-039 Deassert r in the 2nd cycle of a len=5 burst: gnt, acc_b and acc_sel go to 0 immediately; no done; after release, req0 wins a tie.
REQ-040 Change b0 from 3 to 6 mid-burst: acc_b remains 3 until the burst ends.
